// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one input bit per clock.
// Optional two's-complement input is converted as sign plus magnitude.
module bin2bcd_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  sign_out,
  output logic                  overflow,
  output logic [1:0]            state_dbg
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   shreg_q, shreg_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sign_q, sign_d;
  logic               ovf_q, ovf_d;
  logic [BCD_W-1:0]   corr;
  logic               neg;
  logic [BIN_W-1:0]   mag;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; the producer holds valid and data stable until that edge.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign bcd_out   = bcd_q;
  assign sign_out  = sign_q;
  assign overflow  = ovf_q;
  assign state_dbg = state_q;

  assign neg = (SIGNED != 0) & bin_in[BIN_W-1];
  assign mag = neg ? (~bin_in + {{(BIN_W-1){1'b0}}, 1'b1}) : bin_in;

  always_comb begin
    corr = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) corr[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d = mag;
          sign_d  = neg;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = CNT_W'(BIN_W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // A set bit 3 in the top corrected digit is about to leave the register.
        {bcd_d, shreg_d} = {corr[BCD_W-2:0], shreg_q, 1'b0};
        ovf_d = ovf_q | corr[BCD_W-1];
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: default unsigned, signed and 3-digit/10-bit instances
// share clock, reset, operand and out_ready; each has its own in_valid.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst_n;
  logic [2:0]  iv;
  logic [15:0] bin;
  logic        out_ready;

  logic        ir0, ov0, sg0, of0;
  logic        ir1, ov1, sg1, of1;
  logic        ir2, ov2, sg2, of2;
  logic [19:0] bcd0, bcd1;
  logic [11:0] bcd2;
  logic [1:0]  st0, st1, st2;

  int n_checks;
  int n_fail;

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(0)) u_def (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir0), .bin_in(bin),
    .out_valid(ov0), .out_ready(out_ready), .bcd_out(bcd0), .sign_out(sg0),
    .overflow(of0), .state_dbg(st0));

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir1), .bin_in(bin),
    .out_valid(ov1), .out_ready(out_ready), .bcd_out(bcd1), .sign_out(sg1),
    .overflow(of1), .state_dbg(st1));

  bin2bcd_seq #(.BIN_W(10), .DIGITS(3), .SIGNED(0)) u_d3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir2), .bin_in(bin[9:0]),
    .out_valid(ov2), .out_ready(out_ready), .bcd_out(bcd2), .sign_out(sg2),
    .overflow(of2), .state_dbg(st2));

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic sel_ir(input int sel);
    case (sel)
      0: return ir0;
      1: return ir1;
      default: return ir2;
    endcase
  endfunction

  function automatic logic sel_ov(input int sel);
    case (sel)
      0: return ov0;
      1: return ov1;
      default: return ov2;
    endcase
  endfunction

  function automatic logic [19:0] sel_bcd(input int sel);
    case (sel)
      0: return bcd0;
      1: return bcd1;
      default: return {8'h00, bcd2};
    endcase
  endfunction

  function automatic logic sel_sg(input int sel);
    case (sel)
      0: return sg0;
      1: return sg1;
      default: return sg2;
    endcase
  endfunction

  function automatic logic sel_of(input int sel);
    case (sel)
      0: return of0;
      1: return of1;
      default: return of2;
    endcase
  endfunction

  // driver: offer one operand; returns after the accept edge (+1)
  task automatic offer(input int sel, input logic [15:0] val, input string tag);
    @(negedge clk);
    bin = val;
    iv[sel] = 1'b1;
    check({tag, "_in_ready"}, 32'(sel_ir(sel)), 32'd1);
    @(posedge clk);
    #1;
    iv = '0;
  endtask

  // waits for out_valid and checks latency; lat is edges counted after the accept edge
  task automatic wait_done(input int sel, input int exp_lat, input string tag);
    int lat;
    lat = 0;
    while (!sel_ov(sel) && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic take(input int sel, input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, 32'(sel_ov(sel)), 32'd0);
    check({tag, "_in_ready_back"}, 32'(sel_ir(sel)), 32'd1);
  endtask

  task automatic conv(input int sel, input logic [15:0] val, input logic [19:0] eb,
                      input logic es, input logic eo, input string tag);
    int exp_lat;
    exp_lat = (sel == 2) ? 10 : 16;
    offer(sel, val, tag);
    wait_done(sel, exp_lat, tag);
    check({tag, "_bcd"}, 32'(sel_bcd(sel)), 32'(eb));
    check({tag, "_sign"}, 32'(sel_sg(sel)), 32'(es));
    check({tag, "_ovf"}, 32'(sel_of(sel)), 32'(eo));
    take(sel, tag);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    iv = '0;
    bin = '0;
    out_ready = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    check("rst_in_ready", 32'(ir0), 32'd1);
    check("rst_out_valid", 32'(ov0), 32'd0);
    check("rst_bcd", 32'(bcd0), 32'd0);
    check("rst_sign", 32'(sg1), 32'd0);
    check("rst_ovf", 32'(of2), 32'd0);
    check("rst_state", 32'(st0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    conv(0, 16'd0,     20'h00000, 1'b0, 1'b0, "u_zero");
    conv(0, 16'd65535, 20'h65535, 1'b0, 1'b0, "u_max");
    conv(0, 16'd1234,  20'h01234, 1'b0, 1'b0, "u_1234");
    conv(0, 16'd59,    20'h00059, 1'b0, 1'b0, "u_59");

    conv(1, 16'h8000,  20'h32768, 1'b1, 1'b0, "s_minneg");
    conv(1, 16'hFFFF,  20'h00001, 1'b1, 1'b0, "s_minus1");
    conv(1, 16'd100,   20'h00100, 1'b0, 1'b0, "s_pos100");

    conv(2, 16'd1000,  20'h00000, 1'b0, 1'b1, "d3_1000");
    conv(2, 16'd999,   20'h00999, 1'b0, 1'b0, "d3_999");
    conv(2, 16'd1023,  20'h00023, 1'b0, 1'b1, "d3_1023");

    // backpressure: result held for 20 cycles while a second operand is offered
    offer(0, 16'd4321, "bp");
    wait_done(0, 16, "bp");
    @(negedge clk);
    bin = 16'd1111;
    iv[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", 32'(ov0), 32'd1);
      check("bp_bcd", 32'(bcd0), 32'h04321);
      check("bp_in_ready", 32'(ir0), 32'd0);
    end
    iv = '0;
    take(0, "bp");

    // out_ready already high when out_valid rises
    out_ready = 1'b1;
    @(negedge clk);
    bin = 16'd777;
    iv[0] = 1'b1;
    @(posedge clk);
    #1;
    iv = '0;
    out_ready = 1'b1;
    wait_done(0, 16, "ordy");
    check("ordy_bcd", 32'(bcd0), 32'h00777);
    @(posedge clk);
    #1;
    check("ordy_in_ready", 32'(ir0), 32'd1);
    check("ordy_out_valid", 32'(ov0), 32'd0);
    out_ready = 1'b0;

    // asynchronous reset in the middle of a conversion
    offer(0, 16'd9876, "rst_mid");
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rstm_in_ready", 32'(ir0), 32'd1);
    check("rstm_out_valid", 32'(ov0), 32'd0);
    check("rstm_bcd", 32'(bcd0), 32'd0);
    check("rstm_state", 32'(st0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    conv(0, 16'd9876, 20'h09876, 1'b0, 1'b0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
